// File: rtl/rr_sel4_ctrl.sv
// rtl/rr_sel4_ctrl.sv - round-robin 4:1 mux select controller with done/timeout release
module rr_sel4_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       S1,
    output logic       S0,
    output logic [3:0] grant,
    output logic       valid,
    output logic       timeout_pulse
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Last count value before a timeout release; unused when TIMEOUT is 0.
    localparam int            TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TO_LAST   = TO_LAST_I[CW-1:0];
    localparam bit            TO_EN     = (TIMEOUT != 0);

    state_t        state, state_n;
    logic [1:0]    ptr, ptr_n;
    logic [1:0]    sel, sel_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    grant_n;
    logic          valid_n;
    logic          tp_n;

    logic          rel_done;
    logic          rel_to;
    logic          release_now;
    logic [1:0]    arb_ptr;
    logic [1:0]    win;
    logic [1:0]    idx;
    logic          found;

    // Done always wins over a coincident timeout, so timeout release requires done low.
    assign rel_done    = (state == BUSY) && done;
    assign rel_to      = (state == BUSY) && TO_EN && (cnt == TO_LAST) && !done;
    assign release_now = rel_done || rel_to;

    // On release the search starts just past the current winner, in the same edge.
    assign arb_ptr = release_now ? (sel + 2'd1) : ptr;

    // Priority search: first set request at arb_ptr, arb_ptr+1, ... (mod 4).
    always_comb begin
        found = 1'b0;
        win   = arb_ptr;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = arb_ptr + k[1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        cnt_n   = cnt;
        grant_n = grant;
        valid_n = valid;
        tp_n    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = BUSY;
                    sel_n   = win;
                    grant_n = 4'b0001 << win;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_n = sel + 2'd1;
                    tp_n  = rel_to;
                    if (found) begin
                        sel_n   = win;
                        grant_n = 4'b0001 << win;
                        cnt_n   = '0;
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                        grant_n = 4'b0000;
                    end
                end else if (cnt != {CW{1'b1}}) begin
                    // Saturate so a disabled timeout can never wrap the count.
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; outputs never see done combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            sel           <= '0;
            cnt           <= '0;
            grant         <= '0;
            valid         <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            sel           <= sel_n;
            cnt           <= cnt_n;
            grant         <= grant_n;
            valid         <= valid_n;
            timeout_pulse <= tp_n;
        end
    end

    assign S1 = sel[1];
    assign S0 = sel[0];

endmodule

// File: tb/tb_rr_sel4_ctrl.sv
// tb/tb_rr_sel4_ctrl.sv - table-driven bench for rr_sel4_ctrl
module tb_rr_sel4_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;

    logic       s1, s0, valid, tp;
    logic [3:0] grant;
    logic       s1_16, s0_16, valid_16, tp_16;
    logic [3:0] grant_16;

    int total;
    int passed;

    rr_sel4_ctrl #(.TIMEOUT(4), .CW(3)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .S1(s1), .S0(s0), .grant(grant), .valid(valid), .timeout_pulse(tp)
    );

    rr_sel4_ctrl dut16 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .S1(s1_16), .S0(s0_16), .grant(grant_16), .valid(valid_16), .timeout_pulse(tp_16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] g;
        logic       v;
        logic [1:0] s;
        logic       tp;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic [3:0] q, input logic d,
                       input logic [3:0] g, input logic v, input logic [1:0] s, input logic t);
        vec_t x;
        x.rst = r; x.req = q; x.done = d; x.g = g; x.v = v; x.s = s; x.tp = t;
        tv.push_back(x);
    endtask

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s got {grant,valid,S1,S0,tp}=%b required=%b", nm, got, exp);
        else
            passed++;
    endtask

    function automatic logic [7:0] obs();
        return {grant, valid, s1, s0, tp};
    endfunction

    int cyc;

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        done   = 1'b0;
        #2;
        check("reset_no_clock", obs(), 8'b0000_0_00_0);
        check("reset_no_clock_t16", {grant_16, valid_16, s1_16, s0_16, tp_16}, 8'b0);

        //   rst  req      done  grant    v     sel    tp
        add(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'b10, 1'b0); // first grant, 1-cycle latency
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b0); // done -> idle, ptr=3, sel held
        add(1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'b11, 1'b0); // ptr=3 picks input 3
        add(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'b00, 1'b0); // fairness rotation
        add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'b00, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'b01, 1'b0);
        add(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 2'b01, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'b10, 1'b0);
        add(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'b10, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'b11, 1'b0);
        add(1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'b11, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'b00, 1'b0); // wrapped to 0001
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0);
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0); // reset before timeout test
        add(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 2'b00, 1'b0); // timeout: 4 cycles of 0001
        add(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 2'b00, 1'b0);
        add(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 2'b00, 1'b0);
        add(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 2'b00, 1'b0);
        add(1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1, 2'b01, 1'b1); // timeout release + pulse
        add(1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1, 2'b01, 1'b0);
        add(1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1, 2'b01, 1'b0);
        add(1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1, 2'b01, 1'b0);
        add(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 2'b00, 1'b1); // back to 0001
        add(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 2'b00, 1'b0); // collision setup
        add(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 2'b00, 1'b0);
        add(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 2'b00, 1'b0);
        add(1'b0, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'b01, 1'b0); // done at cnt==3: no pulse
        add(1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'b11, 1'b0); // request-dropped setup
        add(1'b0, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'b11, 1'b0); // held although req dropped
        add(1'b0, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'b11, 1'b0);
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'b11, 1'b0); // idle, S1=S0=1 held
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b11, 1'b0);

        foreach (tv[i]) begin
            rst  = tv[i].rst;
            req  = tv[i].req;
            done = tv[i].done;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), obs(), {tv[i].g, tv[i].v, tv[i].s, tv[i].tp});
        end

        // Reset mid-grant: build ptr=1 with grant 0010, then reset asynchronously.
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; req = 4'b0001;
        @(posedge clk); #1;
        check("mid_setup_0001", obs(), 8'b0001_1_00_0);
        req = 4'b0010; done = 1'b1;
        @(posedge clk); #1;
        check("mid_setup_0010", obs(), 8'b0010_1_01_0);
        done = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_async_clear", obs(), 8'b0000_0_00_0);
        #1 rst = 1'b0;
        req = 4'b1111;
        @(posedge clk); #1;
        check("mid_ptr_restart", obs(), 8'b0001_1_00_0);

        // Default TIMEOUT=16: valid held exactly 16 cycles, pulse in the 17th.
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; req = 4'b0001;
        @(posedge clk); #1;
        check("t16_grant", {grant_16, valid_16, s1_16, s0_16, tp_16}, 8'b0001_1_00_0);
        req = 4'b0000;
        cyc = 1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (!valid_16) break;
            cyc++;
        end
        total++;
        if (cyc != 16) $display("FAIL t16_valid_len got=%0d required=16", cyc);
        else passed++;
        check("t16_pulse", {grant_16, valid_16, s1_16, s0_16, tp_16}, 8'b0000_0_00_1);
        @(posedge clk); #1;
        check("t16_pulse_end", {grant_16, valid_16, s1_16, s0_16, tp_16}, 8'b0000_0_00_0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
